vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 60 ++++++
 rtl/vga_axis_counter.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA timing tables shared by the generator and its axis counters: mode codes,
// per-mode region lengths and sync polarities.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 11;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_1024X768 = 2'd2,
        MODE_1440X900 = 2'd3
    } vga_mode_e;

    typedef enum logic [1:0] {
        AX_SYNC    = 2'd0,
        AX_BKPORCH = 2'd1,
        AX_DATA    = 2'd2,
        AX_FTPORCH = 2'd3
    } axis_state_e;

    // Region lengths of one axis, in counter steps.
    typedef struct packed {
        logic [CNT_W-1:0] sync_len;
        logic [CNT_W-1:0] bp_len;
        logic [CNT_W-1:0] data_len;
        logic [CNT_W-1:0] fp_len;
    } axis_timing_t;

    function automatic axis_timing_t h_timing(input vga_mode_e mode);
        axis_timing_t t;
        case (mode)
            MODE_640X480:  t = {CNT_W'(96),  CNT_W'(48),  CNT_W'(640),  CNT_W'(16)};
            MODE_800X600:  t = {CNT_W'(128), CNT_W'(88),  CNT_W'(800),  CNT_W'(40)};
            MODE_1024X768: t = {CNT_W'(136), CNT_W'(160), CNT_W'(1024), CNT_W'(24)};
            default:       t = {CNT_W'(32),  CNT_W'(80),  CNT_W'(1440), CNT_W'(48)};
        endcase
        return t;
    endfunction

    function automatic axis_timing_t v_timing(input vga_mode_e mode);
        axis_timing_t t;
        case (mode)
            MODE_640X480:  t = {CNT_W'(2), CNT_W'(33), CNT_W'(480), CNT_W'(10)};
            MODE_800X600:  t = {CNT_W'(4), CNT_W'(23), CNT_W'(600), CNT_W'(1)};
            MODE_1024X768: t = {CNT_W'(6), CNT_W'(29), CNT_W'(768), CNT_W'(3)};
            default:       t = {CNT_W'(6), CNT_W'(17), CNT_W'(900), CNT_W'(3)};
        endcase
        return t;
    endfunction

    // Active level of the sync pulse: 1 = positive, 0 = negative.
    function automatic logic h_active_pol(input vga_mode_e mode);
        return (mode == MODE_800X600) || (mode == MODE_1440X900);
    endfunction

    function automatic logic v_active_pol(input vga_mode_e mode);
        return (mode == MODE_800X600);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus SYNC/BKPORCH/DATA/FTPORCH region FSM.
// Region lengths may only change while the counter wraps.
module vga_axis_counter
    import vga_timing_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             adv,
    input  axis_timing_t     timing,
    output logic [CNT_W-1:0] count,
    output axis_state_e      state,
    output logic             wrap_c
);

    logic [CNT_W-1:0] bp_start_c;
    logic [CNT_W-1:0] data_start_c;
    logic [CNT_W-1:0] fp_start_c;
    logic [CNT_W-1:0] last_c;
    logic [CNT_W-1:0] count_nxt;
    axis_state_e      state_nxt;

    always_comb begin
        bp_start_c   = timing.sync_len;
        data_start_c = bp_start_c + timing.bp_len;
        fp_start_c   = data_start_c + timing.data_len;
        last_c       = fp_start_c + timing.fp_len - CNT_W'(1);
    end

    assign wrap_c = (count == last_c);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= AX_SYNC;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A region is entered on the step that lands on its first count.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (adv) begin
            if (wrap_c) begin
                count_nxt = '0;
                state_nxt = AX_SYNC;
            end else begin
                count_nxt = count + CNT_W'(1);
                case (state)
                    AX_SYNC:    if (count_nxt == bp_start_c)   state_nxt = AX_BKPORCH;
                    AX_BKPORCH: if (count_nxt == data_start_c) state_nxt = AX_DATA;
                    AX_DATA:    if (count_nxt == fp_start_c)   state_nxt = AX_FTPORCH;
                    AX_FTPORCH: state_nxt = AX_FTPORCH;
                    default:    state_nxt = AX_SYNC;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Multi-mode VGA sync/active-video timing generator with frame-boundary mode switch.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned PRE_LEAD = 1,
    parameter int unsigned MODE_RST = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Clk_En,
    input  logic [1:0]        Mode_Sel,
    output logic              HSYNC_Sig,
    output logic              VSYNC_Sig,
    output logic              Ready_Sig,
    output logic              Pre_Ready_Sig,
    output logic [ADDR_W-1:0] Column_Addr_Sig,
    output logic [ADDR_W-1:0] Row_Addr_Sig,
    output logic              Frame_Start_Sig,
    output logic [1:0]        Mode_Active,
    output logic [15:0]       Frame_Cnt
);

    localparam vga_mode_e        RST_MODE = vga_mode_e'(2'(MODE_RST));
    localparam logic             RST_HS   = h_active_pol(RST_MODE);
    localparam logic             RST_VS   = v_active_pol(RST_MODE);
    localparam logic [CNT_W-1:0] LEAD     = CNT_W'(PRE_LEAD);

    vga_mode_e        mode_q;
    axis_timing_t     h_tim_c;
    axis_timing_t     v_tim_c;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    axis_state_e      h_state;
    axis_state_e      v_state;
    logic             h_wrap_c;
    logic             v_wrap_c;
    logic             v_adv_c;
    logic             frame_end_c;

    logic [CNT_W-1:0]  h_data_start_c;
    logic [CNT_W-1:0]  v_data_start_c;
    logic [CNT_W-1:0]  pre_start_c;
    logic [CNT_W-1:0]  pre_end_c;
    logic              pre_c;
    logic              ready_c;
    logic              hsync_c;
    logic              vsync_c;
    logic              frame_start_c;
    logic [ADDR_W-1:0] col_c;
    logic [ADDR_W-1:0] row_c;

    assign h_tim_c     = h_timing(mode_q);
    assign v_tim_c     = v_timing(mode_q);
    assign v_adv_c     = Clk_En && h_wrap_c;
    assign frame_end_c = Clk_En && h_wrap_c && v_wrap_c;

    vga_axis_counter u_h_axis (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .adv    (Clk_En),
        .timing (h_tim_c),
        .count  (h_count),
        .state  (h_state),
        .wrap_c (h_wrap_c)
    );

    vga_axis_counter u_v_axis (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .adv    (v_adv_c),
        .timing (v_tim_c),
        .count  (v_count),
        .state  (v_state),
        .wrap_c (v_wrap_c)
    );

    // Mode is only swapped on the last pixel of a frame so both axes restart together.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q <= RST_MODE;
        end else if (frame_end_c) begin
            mode_q <= vga_mode_e'(Mode_Sel);
        end
    end

    // Early window is the data window shifted left by PRE_LEAD pixels on data lines.
    always_comb begin
        h_data_start_c = h_tim_c.sync_len + h_tim_c.bp_len;
        v_data_start_c = v_tim_c.sync_len + v_tim_c.bp_len;
        pre_start_c    = h_data_start_c - LEAD;
        pre_end_c      = pre_start_c + h_tim_c.data_len;
        pre_c          = (v_state == AX_DATA) && (h_count >= pre_start_c) && (h_count < pre_end_c);
        ready_c        = (h_state == AX_DATA) && (v_state == AX_DATA);
        col_c          = pre_c ? ADDR_W'(h_count - pre_start_c) : '0;
        row_c          = pre_c ? ADDR_W'(v_count - v_data_start_c) : '0;
        hsync_c        = (h_state == AX_SYNC) ? h_active_pol(mode_q) : ~h_active_pol(mode_q);
        vsync_c        = (v_state == AX_SYNC) ? v_active_pol(mode_q) : ~v_active_pol(mode_q);
        frame_start_c  = (h_count == '0) && (v_count == '0);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            HSYNC_Sig       <= RST_HS;
            VSYNC_Sig       <= RST_VS;
            Ready_Sig       <= 1'b0;
            Pre_Ready_Sig   <= 1'b0;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
            Frame_Start_Sig <= 1'b0;
            Mode_Active     <= RST_MODE;
        end else if (Clk_En) begin
            HSYNC_Sig       <= hsync_c;
            VSYNC_Sig       <= vsync_c;
            Ready_Sig       <= ready_c;
            Pre_Ready_Sig   <= pre_c;
            Column_Addr_Sig <= col_c;
            Row_Addr_Sig    <= row_c;
            Frame_Start_Sig <= frame_start_c;
            Mode_Active     <= mode_q;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts alongside the registered Frame_Start_Sig, so it includes the frame now starting.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Frame_Cnt <= '0;
        end else if (Clk_En && frame_start_c) begin
            Frame_Cnt <= Frame_Cnt + 16'd1;
        end
    end
`else
    assign Frame_Cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (mode 1/lead 1, mode 0/lead 3) checked
// every cycle against a position-based model, plus spec-derived vectors and sequences.
module tb_vga_timing_gen;

    localparam int H_SY[4] = '{96, 128, 136, 32};
    localparam int H_BP[4] = '{48, 88, 160, 80};
    localparam int H_DA[4] = '{640, 800, 1024, 1440};
    localparam int H_FP[4] = '{16, 40, 24, 48};
    localparam int V_SY[4] = '{2, 4, 6, 6};
    localparam int V_BP[4] = '{33, 23, 29, 17};
    localparam int V_DA[4] = '{480, 600, 768, 900};
    localparam int V_FP[4] = '{10, 1, 3, 3};
    localparam int H_PP[4] = '{0, 1, 0, 1};
    localparam int V_PP[4] = '{0, 1, 0, 0};
    localparam int LEAD_T[2] = '{1, 3};
    localparam int RMODE[2]  = '{1, 0};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        rdy;
        logic        pre;
        logic [10:0] col;
        logic [10:0] row;
        logic        fs;
        logic [1:0]  mode;
        logic [15:0] fcnt;
    } out_t;

    typedef struct {
        int   d;
        int   pos;
        logic hs;
        logic vs;
        logic rdy;
        logic pre;
        int   col;
        int   row;
        logic fs;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [1:0]  mode_sel;
    logic        hs   [2];
    logic        vs   [2];
    logic        rdy  [2];
    logic        pre  [2];
    logic [10:0] col  [2];
    logic [10:0] row  [2];
    logic        fs   [2];
    logic [1:0]  mact [2];
    logic [15:0] fcnt [2];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Model state: where each DUT's counters are, and which position its outputs show.
    int cnt_pos   [2];
    int cnt_mode  [2];
    int out_pos   [2];
    int out_mode  [2];
    bit out_valid [2];
    int frames    [2];

    vec_t tbl[18];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen #(.ADDR_W(11), .PRE_LEAD(1), .MODE_RST(1)) u_dut0 (
        .CLK(clk), .RSTn(rst_n), .Clk_En(clk_en), .Mode_Sel(mode_sel),
        .HSYNC_Sig(hs[0]), .VSYNC_Sig(vs[0]), .Ready_Sig(rdy[0]), .Pre_Ready_Sig(pre[0]),
        .Column_Addr_Sig(col[0]), .Row_Addr_Sig(row[0]), .Frame_Start_Sig(fs[0]),
        .Mode_Active(mact[0]), .Frame_Cnt(fcnt[0])
    );

    vga_timing_gen #(.ADDR_W(11), .PRE_LEAD(3), .MODE_RST(0)) u_dut1 (
        .CLK(clk), .RSTn(rst_n), .Clk_En(clk_en), .Mode_Sel(mode_sel),
        .HSYNC_Sig(hs[1]), .VSYNC_Sig(vs[1]), .Ready_Sig(rdy[1]), .Pre_Ready_Sig(pre[1]),
        .Column_Addr_Sig(col[1]), .Row_Addr_Sig(row[1]), .Frame_Start_Sig(fs[1]),
        .Mode_Active(mact[1]), .Frame_Cnt(fcnt[1])
    );

    function automatic int h_tot(input int m);
        return H_SY[m] + H_BP[m] + H_DA[m] + H_FP[m];
    endfunction

    function automatic int v_tot(input int m);
        return V_SY[m] + V_BP[m] + V_DA[m] + V_FP[m];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt_pos[d]   = 0;
            cnt_mode[d]  = RMODE[d];
            out_pos[d]   = 0;
            out_mode[d]  = RMODE[d];
            out_valid[d] = 1'b0;
            frames[d]    = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            out_valid[d] = 1'b1;
            out_pos[d]   = cnt_pos[d];
            out_mode[d]  = cnt_mode[d];
            if (out_pos[d] == 0) frames[d]++;
            if (cnt_pos[d] == h_tot(cnt_mode[d]) * v_tot(cnt_mode[d]) - 1) begin
                cnt_pos[d]  = 0;
                cnt_mode[d] = int'(mode_sel);
            end else begin
                cnt_pos[d]++;
            end
        end
    endtask

    function automatic out_t expected(input int d);
        out_t e;
        int m, h, v, hd0, vd0, ps;
        logic vdat;
        e = '0;
        if (!out_valid[d]) begin
            m      = RMODE[d];
            e.hs   = (H_PP[m] != 0);
            e.vs   = (V_PP[m] != 0);
            e.mode = 2'(m);
            return e;
        end
        m    = out_mode[d];
        h    = out_pos[d] % h_tot(m);
        v    = out_pos[d] / h_tot(m);
        hd0  = H_SY[m] + H_BP[m];
        vd0  = V_SY[m] + V_BP[m];
        ps   = hd0 - LEAD_T[d];
        vdat = (v >= vd0) && (v < vd0 + V_DA[m]);
        e.hs  = (h < H_SY[m]) ? (H_PP[m] != 0) : (H_PP[m] == 0);
        e.vs  = (v < V_SY[m]) ? (V_PP[m] != 0) : (V_PP[m] == 0);
        e.rdy = vdat && (h >= hd0) && (h < hd0 + H_DA[m]);
        e.pre = vdat && (h >= ps) && (h < ps + H_DA[m]);
        if (e.pre) begin
            e.col = 11'(h - ps);
            e.row = 11'(v - vd0);
        end
        e.fs   = (out_pos[d] == 0);
        e.mode = 2'(m);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fcnt = 16'(frames[d]);
`else
        e.fcnt = 16'd0;
`endif
        return e;
    endfunction

    function automatic out_t actual(input int d);
        out_t a;
        a.hs   = hs[d];
        a.vs   = vs[d];
        a.rdy  = rdy[d];
        a.pre  = pre[d];
        a.col  = col[d];
        a.row  = row[d];
        a.fs   = fs[d];
        a.mode = mact[d];
        a.fcnt = fcnt[d];
        return a;
    endfunction

    // One clock: model follows the enabled edge, both DUTs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && clk_en) model_step();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++)
            chk($sformatf("model_d%0d", d), 64'(actual(d)), 64'(expected(d)));
    endtask

    initial begin
        int   guard;
        int   hs_cnt, rdy_cnt, first_rdy, span;
        logic prev;
        logic [15:0] fexp;

        tbl[0]  = '{0, 0,     1'b1, 1'b1, 1'b0, 1'b0, 0,   0, 1'b1};
        tbl[1]  = '{1, 0,     1'b0, 1'b0, 1'b0, 1'b0, 0,   0, 1'b1};
        tbl[2]  = '{1, 96,    1'b1, 1'b0, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[3]  = '{0, 127,   1'b1, 1'b1, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[4]  = '{0, 128,   1'b0, 1'b1, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[5]  = '{0, 1056,  1'b1, 1'b1, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[6]  = '{0, 4224,  1'b1, 1'b0, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[7]  = '{1, 28140, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[8]  = '{1, 28141, 1'b1, 1'b1, 1'b0, 1'b1, 0,   0, 1'b0};
        tbl[9]  = '{1, 28144, 1'b1, 1'b1, 1'b1, 1'b1, 3,   0, 1'b0};
        tbl[10] = '{0, 28727, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 1'b0};
        tbl[11] = '{0, 28728, 1'b0, 1'b0, 1'b1, 1'b1, 1,   0, 1'b0};
        tbl[12] = '{1, 28780, 1'b1, 1'b1, 1'b1, 1'b1, 639, 0, 1'b0};
        tbl[13] = '{1, 28781, 1'b1, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0};
        tbl[14] = '{1, 28784, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0, 1'b0};
        tbl[15] = '{0, 29526, 1'b0, 1'b0, 1'b1, 1'b1, 799, 0, 1'b0};
        tbl[16] = '{0, 29527, 1'b0, 1'b0, 1'b1, 1'b0, 0,   0, 1'b0};
        tbl[17] = '{0, 29784, 1'b0, 1'b0, 1'b1, 1'b1, 1,   1, 1'b0};

        rst_n    = 1'b0;
        clk_en   = 1'b0;
        mode_sel = 2'd1;
        model_reset();
        repeat (3) tick();
        chk("reset_hs0", 64'(hs[0]), 64'(1));
        chk("reset_hs1", 64'(hs[1]), 64'(0));

        rst_n  = 1'b1;
        clk_en = 1'b1;

        // Spec-derived vectors at fixed enabled-cycle positions.
        for (int i = 0; i < 18; i++) begin
            guard = 0;
            while (!(out_valid[0] && out_pos[0] >= tbl[i].pos) && guard < 40000) begin
                tick();
                guard++;
            end
            chk($sformatf("vec%0d_pos", i), 64'(out_pos[0]), 64'(tbl[i].pos));
            chk($sformatf("vec%0d_out", i),
                64'({hs[tbl[i].d], vs[tbl[i].d], rdy[tbl[i].d], pre[tbl[i].d],
                     col[tbl[i].d], row[tbl[i].d], fs[tbl[i].d]}),
                64'({tbl[i].hs, tbl[i].vs, tbl[i].rdy, tbl[i].pre,
                     11'(tbl[i].col), 11'(tbl[i].row), tbl[i].fs}));
        end

        // Mode 1 data line: 128 sync cycles, 800 ready cycles starting 216 after sync.
        prev  = hs[0];
        guard = 0;
        while (!(hs[0] && !prev) && guard < 1200) begin
            prev = hs[0];
            tick();
            guard++;
        end
        chk("line_find_hs", 64'(guard < 1200), 64'(1));
        hs_cnt = 0; rdy_cnt = 0; first_rdy = -1;
        for (int i = 0; i < 1056; i++) begin
            if (hs[0]) hs_cnt++;
            if (rdy[0]) begin
                rdy_cnt++;
                if (first_rdy < 0) first_rdy = i;
            end
            tick();
        end
        chk("line_hs_len", 64'(hs_cnt), 64'(128));
        chk("line_rdy_len", 64'(rdy_cnt), 64'(800));
        chk("line_rdy_delay", 64'(first_rdy), 64'(216));

        // Clk_En alternating 1,0: one mode 1 line spans 2112 clocks.
        prev  = hs[0];
        guard = 0;
        while (!(hs[0] && !prev) && guard < 2500) begin
            prev   = hs[0];
            clk_en = ~clk_en;
            tick();
            guard++;
        end
        chk("toggle_find_hs", 64'(guard < 2500), 64'(1));
        span = 0;
        prev = hs[0];
        do begin
            prev   = hs[0];
            clk_en = ~clk_en;
            tick();
            span++;
        end while (!(hs[0] && !prev) && span < 3000);
        chk("toggle_line_clocks", 64'(span), 64'(2112));

        // Random enable with mid-frame mode requests; they must not take effect.
        for (int i = 0; i < 3000; i++) begin
            clk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) mode_sel = 2'($urandom_range(0, 3));
            tick();
        end
        chk("midframe_mode0", 64'(mact[0]), 64'(1));
        chk("midframe_mode1", 64'(mact[1]), 64'(0));

        // Reset mid-frame, then restart from the first pixel.
        mode_sel = 2'd1;
        rst_n    = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            clk_en = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_mid_rdy", 64'(rdy[0]), 64'(0));
        chk("rst_mid_fcnt", 64'(fcnt[0]), 64'(0));
        rst_n  = 1'b1;
        clk_en = 1'b1;
        tick();
`ifdef VGA_TIMING_FRAME_CNT_EN
        fexp = 16'd1;
`else
        fexp = 16'd0;
`endif
        chk("restart_fs0", 64'(fs[0]), 64'(1));
        chk("restart_fs1", 64'(fs[1]), 64'(1));
        chk("restart_fcnt", 64'(fcnt[0]), 64'(fexp));
        repeat (300) tick();
        chk("after_fs0", 64'(fs[0]), 64'(0));
        chk("after_fcnt", 64'(fcnt[0]), 64'(fexp));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
